uart_controller: RTL

- Data-bus responder for the UART window. It is the slave end of the same bus the CPU data port drives: read, write, address, data_wr, mask in; data_rd, stall out.
- Contains a buffered 8N1 transmitter and receiver, a DATA register and a STATUS register.
- Sits behind data_bus on the uart slave port and drives the board UART pins.

---
 rtl/uart_controller.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_controller.sv
// -----------------------------------------------------------------------------
// uart_controller
//   Data-bus slave for the UART window. It holds a buffered 8N1 transmitter and
//   receiver, a DATA register (TX push / RX pop) and a STATUS register.
//
//   Register map (address[3:2]):
//     0 DATA   : read  -> {24'b0, RX head}, pops the head
//                write -> pushes data_wr[7:0] into the TX FIFO (mask[0])
//     1 STATUS : read  -> {27'b0, frame_err, rx_overrun, tx_idle, rx_valid, tx_ready}
//                write -> data_wr[3] clears rx_overrun, data_wr[4] clears frame_err
//     2,3      : read 0, writes ignored
//
//   Ports:
//     clk      system clock, all logic on its rising edge
//     rst      synchronous active-high reset
//     read     bus read request
//     write    bus write request (wins over read when both are high)
//     address  byte address, only bits [3:2] decoded
//     data_wr  write data
//     mask     byte enables, only mask[0] used
//     data_rd  combinational read data, zero when read is low
//     stall    combinational, high while a DATA write finds the TX FIFO full
//     txd      serial output, idle high
//     rxd      serial input, asynchronous to clk
//
//   Optional build macro UART_LOOPBACK_EN: the receiver listens to the internal
//   txd instead of the rxd pin; txd is still driven to the pin.
// -----------------------------------------------------------------------------
module uart_controller #(
    parameter int CLKS_PER_BIT  = 347,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] data_wr,
    input  logic [3:0]  mask,
    output logic [31:0] data_rd,
    output logic        stall,
    output logic        txd,
    input  logic        rxd
);

    localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
    localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TX_AW:0]   TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW:0]   RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // ---------------------------------------------------------------- bus decode
    logic sel_data_s;
    logic sel_status_s;
    logic tx_push_s;
    logic rx_pop_s;
    logic status_wr_s;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]     tx_mem_r [TX_FIFO_DEPTH];
    logic [TX_AW:0] tx_wptr_r;
    logic [TX_AW:0] tx_rptr_r;
    logic           tx_empty_s;
    logic           tx_full_s;
    logic [7:0]     tx_head_s;
    logic           tx_pop_s;

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]     rx_mem_r [RX_FIFO_DEPTH];
    logic [RX_AW:0] rx_wptr_r;
    logic [RX_AW:0] rx_rptr_r;
    logic           rx_empty_s;
    logic           rx_full_s;
    logic [7:0]     rx_head_s;
    logic           rx_push_s;

    // ---------------------------------------------------------------- TX FSM
    uart_state_t tx_state_r, tx_state_nx_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_nx_s;
    logic [2:0]    tx_bit_r, tx_bit_nx_s;
    logic [7:0]    tx_shift_r, tx_shift_nx_s;
    logic          txd_r, txd_nx_s;

    // ---------------------------------------------------------------- RX FSM
    uart_state_t rx_state_r, rx_state_nx_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_nx_s;
    logic [2:0]    rx_bit_r, rx_bit_nx_s;
    logic [7:0]    rx_shift_r, rx_shift_nx_s;
    logic          rx_line_s;
    logic          rxd_meta_r;
    logic          rxd_sync_r;
    logic          rxd_prev_r;
    logic          set_ovr_s;
    logic          set_ferr_s;

    // ---------------------------------------------------------------- status
    logic        ovr_r;
    logic        ferr_r;
    logic [31:0] status_s;
    logic        unused_bits_s;

    assign sel_data_s   = (address[3:2] == 2'd0);
    assign sel_status_s = (address[3:2] == 2'd1);

    // stall and push both use the pre-edge full flag, so a pop by the shifter
    // in the same cycle never lets a stalled write slip through early.
    assign stall       = write & sel_data_s & mask[0] & tx_full_s;
    assign tx_push_s   = write & sel_data_s & mask[0] & ~tx_full_s;
    // A simultaneous write takes priority, so a read only pops when write is low.
    assign rx_pop_s    = read & ~write & sel_data_s & ~rx_empty_s;
    assign status_wr_s = write & sel_status_s & mask[0];

    assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
    assign tx_full_s  = (tx_wptr_r[TX_AW] != tx_rptr_r[TX_AW]) &&
                        (tx_wptr_r[TX_AW-1:0] == tx_rptr_r[TX_AW-1:0]);
    assign tx_head_s  = tx_mem_r[tx_rptr_r[TX_AW-1:0]];

    assign rx_empty_s = (rx_wptr_r == rx_rptr_r);
    assign rx_full_s  = (rx_wptr_r[RX_AW] != rx_rptr_r[RX_AW]) &&
                        (rx_wptr_r[RX_AW-1:0] == rx_rptr_r[RX_AW-1:0]);
    assign rx_head_s  = rx_mem_r[rx_rptr_r[RX_AW-1:0]];

    assign txd = txd_r;

`ifdef UART_LOOPBACK_EN
    assign rx_line_s     = txd_r;
    assign unused_bits_s = ^{address[31:4], address[1:0], data_wr[31:8], mask[3:1], rxd};
`else
    assign rx_line_s     = rxd;
    assign unused_bits_s = ^{address[31:4], address[1:0], data_wr[31:8], mask[3:1]};
`endif

    assign status_s = {27'd0, ferr_r, ovr_r,
                       (tx_empty_s & (tx_state_r == ST_IDLE)),
                       ~rx_empty_s, ~tx_full_s};

    // Read data mux; an empty RX FIFO reads as zero.
    always_comb begin
        data_rd = 32'd0;
        if (read) begin
            case (address[3:2])
                2'd0: begin
                    if (rx_empty_s) begin
                        data_rd = 32'd0;
                    end else begin
                        data_rd = {24'd0, rx_head_s};
                    end
                end
                2'd1:    data_rd = status_s;
                default: data_rd = 32'd0;
            endcase
        end else begin
            data_rd = 32'd0;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wptr_r[TX_AW-1:0]] <= data_wr[7:0];
        end
    end

    // TX FIFO pointers; push and pop may happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_r <= {(TX_AW+1){1'b0}};
            tx_rptr_r <= {(TX_AW+1){1'b0}};
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + TX_PTR_ONE;
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + TX_PTR_ONE;
        end
    end

    // TX next-state logic; txd is computed one cycle ahead and registered.
    always_comb begin
        tx_state_nx_s = tx_state_r;
        tx_cnt_nx_s   = tx_cnt_r;
        tx_bit_nx_s   = tx_bit_r;
        tx_shift_nx_s = tx_shift_r;
        txd_nx_s      = txd_r;
        tx_pop_s      = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                txd_nx_s = 1'b1;
                if (!tx_empty_s) begin
                    tx_pop_s      = 1'b1;
                    tx_shift_nx_s = tx_head_s;
                    tx_state_nx_s = ST_START;
                    tx_cnt_nx_s   = CNT_ZERO;
                    txd_nx_s      = 1'b0;
                end else begin
                    tx_state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_state_nx_s = ST_DATA;
                    tx_cnt_nx_s   = CNT_ZERO;
                    tx_bit_nx_s   = 3'd0;
                    txd_nx_s      = tx_shift_r[0];
                end else begin
                    tx_cnt_nx_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_nx_s = CNT_ZERO;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_nx_s = ST_STOP;
                        txd_nx_s      = 1'b1;
                    end else begin
                        tx_bit_nx_s   = tx_bit_r + 3'd1;
                        tx_shift_nx_s = {1'b0, tx_shift_r[7:1]};
                        txd_nx_s      = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_nx_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_nx_s = CNT_ZERO;
                    // Chain straight into the next start bit when more data waits.
                    if (!tx_empty_s) begin
                        tx_pop_s      = 1'b1;
                        tx_shift_nx_s = tx_head_s;
                        tx_state_nx_s = ST_START;
                        txd_nx_s      = 1'b0;
                    end else begin
                        tx_state_nx_s = ST_IDLE;
                        txd_nx_s      = 1'b1;
                    end
                end else begin
                    tx_cnt_nx_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_nx_s = ST_IDLE;
                txd_nx_s      = 1'b1;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_nx_s;
            tx_cnt_r   <= tx_cnt_nx_s;
            tx_bit_r   <= tx_bit_nx_s;
            tx_shift_r <= tx_shift_nx_s;
            txd_r      <= txd_nx_s;
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= rx_line_s;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // RX next-state logic; samples are taken mid-bit after the half-bit start delay.
    always_comb begin
        rx_state_nx_s = rx_state_r;
        rx_cnt_nx_s   = rx_cnt_r;
        rx_bit_nx_s   = rx_bit_r;
        rx_shift_nx_s = rx_shift_r;
        rx_push_s     = 1'b0;
        set_ovr_s     = 1'b0;
        set_ferr_s    = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                if (rxd_prev_r && !rxd_sync_r) begin
                    rx_state_nx_s = ST_START;
                    rx_cnt_nx_s   = CNT_ZERO;
                end else begin
                    rx_state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_nx_s = CNT_ZERO;
                    rx_bit_nx_s = 3'd0;
                    // A line already back high at mid-start is treated as a glitch.
                    if (rxd_sync_r) begin
                        rx_state_nx_s = ST_IDLE;
                    end else begin
                        rx_state_nx_s = ST_DATA;
                    end
                end else begin
                    rx_cnt_nx_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_nx_s   = CNT_ZERO;
                    rx_shift_nx_s = {rxd_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_nx_s = ST_STOP;
                    end else begin
                        rx_bit_nx_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_nx_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_nx_s   = CNT_ZERO;
                    rx_state_nx_s = ST_IDLE;
                    if (!rxd_sync_r) begin
                        set_ferr_s = 1'b1;
                    end else if (!rx_full_s || rx_pop_s) begin
                        rx_push_s = 1'b1;
                    end else begin
                        set_ovr_s = 1'b1;
                    end
                end else begin
                    rx_cnt_nx_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_nx_s = ST_IDLE;
            end
        endcase
    end

    // RX state register; reset discards any partially received byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_state_r <= rx_state_nx_s;
            rx_cnt_r   <= rx_cnt_nx_s;
            rx_bit_r   <= rx_bit_nx_s;
            rx_shift_r <= rx_shift_nx_s;
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wptr_r[RX_AW-1:0]] <= rx_shift_r;
        end
    end

    // RX FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_r <= {(RX_AW+1){1'b0}};
            rx_rptr_r <= {(RX_AW+1){1'b0}};
        end else begin
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + RX_PTR_ONE;
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + RX_PTR_ONE;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (set_ovr_s)                        ovr_r <= 1'b1;
            else if (status_wr_s && data_wr[3])   ovr_r <= 1'b0;
            if (set_ferr_s)                       ferr_r <= 1'b1;
            else if (status_wr_s && data_wr[4])   ferr_r <= 1'b0;
        end
    end

endmodule
